// File: rtl/lpc_ior_reg_bank_pkg.sv
// Board register map constants and helpers for the LPC I/O-read register bank.
package lpc_reg_pkg;

  localparam logic [7:0] FPGAID           = 8'h5A;
  localparam logic [7:0] VERSION          = 8'h12;
  localparam logic [7:0] LPC_DEFAULT_DATA = 8'hFF;

  // Register indices of the current board map.
  localparam int BOARD_NUM_REGS = 32;
  localparam int REG_FPGAID     = 0;
  localparam int REG_VERSION    = 1;
  localparam int REG_EVENTS     = 9;
  localparam int REG_TACH_LO    = 10;
  localparam int REG_TACH_HI    = 11;
  localparam int REG_CNT_LO     = 12;
  localparam int REG_CNT_HI     = 13;

  // Event byte: bit 5 is a sticky clear-on-read latch.
  localparam logic [8*BOARD_NUM_REGS-1:0] BOARD_COR_MASK =
    (8*BOARD_NUM_REGS)'(8'h20) << (8 * REG_EVENTS);

  // Tach and counter are read as coherent 16-bit pairs.
  localparam logic [BOARD_NUM_REGS-1:0] BOARD_SNAP_MASK =
    (BOARD_NUM_REGS'(1) << REG_TACH_LO) | (BOARD_NUM_REGS'(1) << REG_CNT_LO);

  // Width of the register index inside the window (at least one bit).
  function automatic int idx_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/lpc_ior_reg_bank_if.sv
// LPC read-request / read-response signals between the slave front-end and the register bank.
interface lpc_ior_reg_bank_if;

  logic [15:0] DevAddr;
  logic        RdDev_En;
  logic [7:0]  RdDev_Data;
  logic        RdDev_Valid;
  logic        RdDev_Hit;

  modport master (
    output DevAddr, RdDev_En,
    input  RdDev_Data, RdDev_Valid, RdDev_Hit
  );

  modport slave (
    input  DevAddr, RdDev_En,
    output RdDev_Data, RdDev_Valid, RdDev_Hit
  );

endinterface

// File: rtl/lpc_ior_reg_bank_sticky.sv
// 8-bit sticky clear-on-read cell: a bit sets on an event pulse and clears on a read of
// its register. Bits outside MASK are held at zero and reduce to constants in synthesis.
module lpc_sticky_byte #(
  parameter logic [7:0] MASK = 8'h00
) (
  input  logic       Mclk,
  input  logic       ResetN,
  input  logic [7:0] event_i,
  input  logic       clr_i,
  output logic [7:0] sticky_o
);

  logic [7:0] sticky_q;
  logic [7:0] sticky_d;

  // Set wins over clear so an event coincident with the clearing read is kept.
  assign sticky_d = ((sticky_q & ~{8{clr_i}}) | event_i) & MASK;

  // Sticky state register with synchronous reset.
  always_ff @(posedge Mclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!ResetN) begin
      sticky_q <= 8'h00;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;

endmodule

// File: rtl/lpc_ior_reg_bank.sv
// LPC I/O-read register bank: window decode, per-byte live/sticky composition,
// one shared 16-bit pair snapshot slot and registered read response (1-cycle latency).
module lpc_ior_reg_bank
  import lpc_reg_pkg::*;
#(
  parameter int                    NUM_REGS     = 32,
  parameter logic [15:0]           BASE_ADDR    = 16'h0000,
  parameter logic [15:0]           DEC_MASK     = 16'hFFE0,
  parameter logic [NUM_REGS-1:0]   IMPL_MASK    = '1,
  parameter logic [8*NUM_REGS-1:0] COR_MASK     = '0,
  parameter logic [NUM_REGS-1:0]   SNAP_MASK    = '0,
  parameter logic [7:0]            DEFAULT_DATA = LPC_DEFAULT_DATA
) (
  input  logic                    Mclk,
  input  logic                    ResetN,
  lpc_ior_reg_bank_if.slave       lpc,
  input  logic [8*NUM_REGS-1:0]   RegIn,
  input  logic [8*NUM_REGS-1:0]   EventIn
);

  localparam int IDX_W = idx_width(NUM_REGS);
  localparam int DEPTH = 1 << IDX_W;

  // Masks padded to the full index range; padded entries read as unimplemented.
  // The top register can never be a pair low byte, so its SNAP bit is dropped.
  localparam logic [DEPTH-1:0] IMPL_PAD = DEPTH'(IMPL_MASK);
  localparam logic [DEPTH-1:0] SNAP_PAD = DEPTH'({1'b0, SNAP_MASK[NUM_REGS-2:0]});

  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             capture;
  logic             snap_rd;
  logic [7:0]       rd_byte;
  logic [7:0]       comp [DEPTH];
  logic [NUM_REGS-1:0] clr;

  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             hit_q, hit_d;
  logic [7:0]       snap_q, snap_d;
  logic             snap_valid_q, snap_valid_d;
  logic [IDX_W-1:0] snap_idx_q, snap_idx_d;

  assign hit     = lpc.RdDev_En && ((lpc.DevAddr & DEC_MASK) == BASE_ADDR);
  assign idx     = lpc.DevAddr[IDX_W-1:0];
  assign idx_nxt = idx + 1'b1;
  assign capture = hit && SNAP_PAD[idx];
  assign snap_rd = hit && snap_valid_q && (snap_idx_q == idx);

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i < NUM_REGS) begin : g_impl
      logic [7:0] sticky;

      // A high byte served from the snapshot keeps its live sticky bits: events that
      // arrived after the capture have not been reported yet.
      assign clr[i] = (hit && !snap_rd && (idx == IDX_W'(i))) ||
                      (capture && (idx_nxt == IDX_W'(i)));

      lpc_sticky_byte #(
        .MASK (COR_MASK[8*i +: 8])
      ) u_sticky (
        .Mclk     (Mclk),
        .ResetN   (ResetN),
        .event_i  (EventIn[8*i +: 8]),
        .clr_i    (clr[i]),
        .sticky_o (sticky)
      );

      assign comp[i] = (COR_MASK[8*i +: 8] & sticky) | (~COR_MASK[8*i +: 8] & RegIn[8*i +: 8]);
    end else begin : g_pad
      assign comp[i] = DEFAULT_DATA;
    end
  end

  // Read mux, snapshot slot next state and response next state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rd_byte      = comp[idx];
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    snap_idx_d   = snap_idx_q;

    if (!IMPL_PAD[idx]) begin
      rd_byte = DEFAULT_DATA;
    end else if (snap_rd) begin
      rd_byte = snap_q;
    end

    if (capture) begin
      snap_d       = comp[idx_nxt];
      snap_valid_d = 1'b1;
      snap_idx_d   = idx_nxt;
    end else if (snap_rd) begin
      snap_valid_d = 1'b0;
    end

    data_d  = hit ? rd_byte : data_q;
    valid_d = hit;
    hit_d   = hit;
  end

  // Response and snapshot registers; a reset during a read discards it.
  always_ff @(posedge Mclk) begin
    if (!ResetN) begin
      data_q       <= DEFAULT_DATA;
      valid_q      <= 1'b0;
      hit_q        <= 1'b0;
      snap_q       <= 8'h00;
      snap_valid_q <= 1'b0;
      snap_idx_q   <= '0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      hit_q        <= hit_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      snap_idx_q   <= snap_idx_d;
    end
  end

  assign lpc.RdDev_Data  = data_q;
  assign lpc.RdDev_Valid = valid_q;
  assign lpc.RdDev_Hit   = hit_q;

endmodule

// File: tb/tb_lpc_ior_reg_bank.sv
// Directed self-checking bench for lpc_ior_reg_bank: 24-register window with an
// unimplemented register 2, a COR bit in register 9 and a snapshot pair at 10/11.
module tb_lpc_ior_reg_bank;
  import lpc_reg_pkg::*;

  localparam int              N      = 24;
  localparam logic [N-1:0]    T_IMPL = 24'hFF_FFFB;
  localparam logic [8*N-1:0]  T_COR  = (8*N)'(8'h20) << (8 * 9);
  localparam logic [N-1:0]    T_SNAP = 24'h00_0400;

  logic         Mclk = 1'b0;
  logic         ResetN;
  logic [8*N-1:0] reg_in;
  logic [8*N-1:0] event_in;

  int n_checks = 0;
  int n_pass   = 0;

  lpc_ior_reg_bank_if lpc ();

  lpc_ior_reg_bank #(
    .NUM_REGS     (N),
    .BASE_ADDR    (16'h0000),
    .DEC_MASK     (16'hFFE0),
    .IMPL_MASK    (T_IMPL),
    .COR_MASK     (T_COR),
    .SNAP_MASK    (T_SNAP),
    .DEFAULT_DATA (8'hFF)
  ) dut (
    .Mclk    (Mclk),
    .ResetN  (ResetN),
    .lpc     (lpc),
    .RegIn   (reg_in),
    .EventIn (event_in)
  );

  always #5 Mclk = ~Mclk;

  typedef struct {
    string       name;
    logic        en;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        valid;
    logic        hit;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive one request at the falling edge; return 1 time unit after the sampling edge.
  task automatic rd(input logic en, input logic [15:0] addr);
    @(negedge Mclk);
    lpc.RdDev_En = en;
    lpc.DevAddr  = addr;
    @(posedge Mclk);
    #1;
  endtask

  task automatic rd_check(input string name, input logic [15:0] addr, input logic [7:0] exp);
    rd(1'b1, addr);
    check({name, ".data"}, 32'(lpc.RdDev_Data), 32'(exp));
    check({name, ".valid"}, 32'(lpc.RdDev_Valid), 32'd1);
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    reg_in[8*i +: 8] = v;
  endtask

  initial begin
    vecs[0] = '{"plain_5",     1'b1, 16'h0005, 8'hA5, 1'b1, 1'b1};
    vecs[1] = '{"miss_25",     1'b1, 16'h0025, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{"idle",        1'b0, 16'h0005, 8'hA5, 1'b0, 1'b0};
    vecs[3] = '{"plain_0",     1'b1, 16'h0000, 8'h30, 1'b1, 1'b1};
    vecs[4] = '{"unimpl_2",    1'b1, 16'h0002, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{"range_1c",    1'b1, 16'h001C, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{"top_17",      1'b1, 16'h0017, 8'h47, 1'b1, 1'b1};
    vecs[7] = '{"plain_1",     1'b1, 16'h0001, 8'h31, 1'b1, 1'b1};
    vecs[8] = '{"miss_1005",   1'b1, 16'h1005, 8'h31, 1'b0, 1'b0};
    vecs[9] = '{"cor_rst_9",   1'b1, 16'h0009, 8'h19, 1'b1, 1'b1};

    for (int i = 0; i < N; i++) reg_in[8*i +: 8] = 8'(8'h30 + i);
    set_byte(5, 8'hA5);
    event_in     = '0;
    lpc.RdDev_En = 1'b0;
    lpc.DevAddr  = 16'h0000;

    // Reset held for two edges.
    ResetN = 1'b0;
    repeat (2) @(posedge Mclk);
    #1;
    check("reset.data",  32'(lpc.RdDev_Data),  32'hFF);
    check("reset.valid", 32'(lpc.RdDev_Valid), 32'd0);
    check("reset.hit",   32'(lpc.RdDev_Hit),   32'd0);
    @(negedge Mclk);
    ResetN = 1'b1;

    // Table-driven single reads.
    for (int v = 0; v < 10; v++) begin
      rd(vecs[v].en, vecs[v].addr);
      check({vecs[v].name, ".data"},  32'(lpc.RdDev_Data),  32'(vecs[v].data));
      check({vecs[v].name, ".valid"}, 32'(lpc.RdDev_Valid), 32'(vecs[v].valid));
      check({vecs[v].name, ".hit"},   32'(lpc.RdDev_Hit),   32'(vecs[v].hit));
    end

    // COR: live byte 9 = 0x39, bit 5 replaced by the sticky latch.
    event_in[8*9 + 5] = 1'b1;
    rd(1'b0, 16'h0000);
    event_in = '0;
    rd_check("cor_set",   16'h0009, 8'h39);
    rd_check("cor_clr",   16'h0009, 8'h19);
    event_in[8*9 + 5] = 1'b1;
    rd_check("cor_coinc", 16'h0009, 8'h19);
    event_in = '0;
    rd_check("cor_kept",  16'h0009, 8'h39);
    rd_check("cor_clr2",  16'h0009, 8'h19);

    // Snapshot pair 10/11, with an unrelated read in between.
    set_byte(10, 8'hFF);
    set_byte(11, 8'h12);
    rd_check("snap_lo",    16'h000A, 8'hFF);
    set_byte(10, 8'h00);
    set_byte(11, 8'h13);
    rd_check("snap_other", 16'h0005, 8'hA5);
    rd_check("snap_hi",    16'h000B, 8'h12);
    rd_check("snap_live",  16'h000B, 8'h13);

    // Back-to-back reads every cycle.
    rd_check("b2b_0", 16'h0000, 8'h30);
    rd_check("b2b_1", 16'h0001, 8'h31);
    rd_check("b2b_5", 16'h0005, 8'hA5);
    rd_check("b2b_0b", 16'h0000, 8'h30);
    rd_check("b2b_snap", 16'h000A, 8'h00);

    // Reset with a read in flight: read discarded, snapshot slot cleared.
    @(negedge Mclk);
    ResetN       = 1'b0;
    lpc.RdDev_En = 1'b1;
    lpc.DevAddr  = 16'h000B;
    @(posedge Mclk);
    #1;
    check("midrst.data",  32'(lpc.RdDev_Data),  32'hFF);
    check("midrst.valid", 32'(lpc.RdDev_Valid), 32'd0);
    check("midrst.hit",   32'(lpc.RdDev_Hit),   32'd0);
    @(negedge Mclk);
    ResetN       = 1'b1;
    lpc.RdDev_En = 1'b0;
    set_byte(11, 8'h55);
    rd_check("post_rst_hi", 16'h000B, 8'h55);
    rd(1'b0, 16'h0000);
    check("post_rst_idle.valid", 32'(lpc.RdDev_Valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
